// File: rtl/ws2812b_pkg.sv
// Shared WS2812B definitions: receiver state encoding, GRB field layout and
// the default 12 MHz timing constants used by both transmitter and receiver.
package ws2812b_pkg;

    typedef enum logic [1:0] {
        RX_SYNC     = 2'd0,
        RX_IDLE_LOW = 2'd1,
        RX_HIGH     = 2'd2,
        RX_LOW      = 2'd3
    } rx_state_t;

    // GRB pixel field offsets (green is sent first)
    localparam int G_MSB = 23;
    localparam int R_MSB = 15;
    localparam int B_MSB = 7;

    // Transmit bit shapes at 12 MHz (high/low cycles for '0' and '1')
    localparam int T0H_CYC = 5;
    localparam int T0L_CYC = 10;
    localparam int T1H_CYC = 10;
    localparam int T1L_CYC = 5;

    // Receive decision thresholds at 12 MHz
    localparam int T_THRESH_DEF   = 7;
    localparam int T_MIN_HIGH_DEF = 2;
    localparam int T_MAX_HIGH_DEF = 14;
    localparam int T_RESET_DEF    = 600;
    localparam int NUM_PIXELS_DEF = 64;

    // Assemble a GRB word from its three colour bytes
    function automatic logic [23:0] grb_pack(input logic [7:0] g,
                                             input logic [7:0] r,
                                             input logic [7:0] b);
        return {g, r, b};
    endfunction

endpackage

// File: rtl/ws2812b_rx_if.sv
// Decoded-pixel output bundle of the WS2812B receiver.
interface ws2812b_rx_if #(
    parameter int IDX_W = 6
);
    logic [23:0]      pixel_data;
    logic             pixel_valid;
    logic [IDX_W-1:0] pixel_index;
    logic             frame_done;
    logic             frame_error;

    modport master (
        output pixel_data,
        output pixel_valid,
        output pixel_index,
        output frame_done,
        output frame_error
    );

    modport slave (
        input pixel_data,
        input pixel_valid,
        input pixel_index,
        input frame_done,
        input frame_error
    );
endinterface

// File: rtl/ws2812b_rx_sync.sv
// Two-flop synchronizer bringing the asynchronous data line into clk.
module ws2812b_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    // Next values: each stage simply copies its predecessor
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer flops, cleared to the idle-low line level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/ws2812b_rx.sv
// WS2812B receiver: measures synchronized high/low times, decodes bits into
// 24-bit GRB pixels, tracks the pixel index and flags frame ends and errors.
module ws2812b_rx
    import ws2812b_pkg::*;
#(
    parameter int T_THRESH   = T_THRESH_DEF,
    parameter int T_MIN_HIGH = T_MIN_HIGH_DEF,
    parameter int T_MAX_HIGH = T_MAX_HIGH_DEF,
    parameter int T_RESET    = T_RESET_DEF,
    parameter int NUM_PIXELS = NUM_PIXELS_DEF,
    parameter int IDX_W      = $clog2(NUM_PIXELS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          serial_in,
    ws2812b_rx_if.master  rx
);
    // Counter widths: high time saturates one past the limit, low time at
    // the gap length, pixel count at NUM_PIXELS.
    localparam int HC_W = $clog2(T_MAX_HIGH + 2);
    localparam int LC_W = $clog2(T_RESET + 1);
    localparam int PC_W = $clog2(NUM_PIXELS + 1);

    localparam logic [HC_W-1:0] HC_ONE    = HC_W'(1);
    localparam logic [HC_W-1:0] HC_THRESH = HC_W'(T_THRESH);
    localparam logic [HC_W-1:0] HC_MIN    = HC_W'(T_MIN_HIGH);
    localparam logic [HC_W-1:0] HC_MAX    = HC_W'(T_MAX_HIGH);
    localparam logic [HC_W-1:0] HC_SAT    = HC_W'(T_MAX_HIGH + 1);
    localparam logic [LC_W-1:0] LC_ONE    = LC_W'(1);
    localparam logic [LC_W-1:0] LC_RESET  = LC_W'(T_RESET);
    localparam logic [PC_W-1:0] PC_ONE    = PC_W'(1);
    localparam logic [PC_W-1:0] PC_MAX    = PC_W'(NUM_PIXELS);
    localparam logic [4:0]      BIT_LAST  = 5'd23;

    logic s_in;

    rx_state_t        state_q, state_d;
    logic [HC_W-1:0]  high_cnt_q, high_cnt_d;
    logic [LC_W-1:0]  low_cnt_q, low_cnt_d;
    logic [4:0]       bit_cnt_q, bit_cnt_d;
    logic [PC_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic [22:0]      shift_q, shift_d;
    logic             overflow_q, overflow_d;
    logic [23:0]      pixel_data_q, pixel_data_d;
    logic [IDX_W-1:0] pixel_index_q, pixel_index_d;
    logic             pixel_valid_q, pixel_valid_d;
    logic             frame_done_q, frame_done_d;
    logic             frame_error_q, frame_error_d;

    logic [HC_W-1:0]  high_inc;
    logic [LC_W-1:0]  low_inc;
    logic             high_too_long;
    logic             high_too_short;
    logic             proto_err;
    logic             bit_done;
    logic             bit_val;
    logic             pix_done;
    logic             pix_room;
    logic             sync_armed;
    logic             gap_seen;

    ws2812b_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (serial_in),
        .q     (s_in)
    );

    // Shared event decode used by both the next-state and datapath logic
    assign high_inc       = (high_cnt_q == HC_SAT) ? HC_SAT : high_cnt_q + HC_ONE;
    assign low_inc        = (low_cnt_q == LC_RESET) ? LC_RESET : low_cnt_q + LC_ONE;
    assign high_too_long  = (state_q == RX_HIGH) && s_in && (high_inc > HC_MAX);
    assign high_too_short = (state_q == RX_HIGH) && !s_in && (high_cnt_q < HC_MIN);
    assign proto_err      = high_too_long || high_too_short;
    assign bit_done       = (state_q == RX_HIGH) && !s_in && !high_too_short;
    assign bit_val        = (high_cnt_q >= HC_THRESH);
    assign pix_done       = bit_done && (bit_cnt_q == BIT_LAST);
    assign pix_room       = (pix_cnt_q < PC_MAX);
    assign sync_armed     = (state_q == RX_SYNC) && !s_in && (low_inc == LC_RESET);
    assign gap_seen       = (state_q == RX_LOW) && !s_in && (low_inc == LC_RESET);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RX_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: arm after a full gap, then follow high/low phases
    always_comb begin
        state_d = state_q;
        case (state_q)
            RX_SYNC:     if (sync_armed) state_d = RX_IDLE_LOW;
            RX_IDLE_LOW: if (s_in) state_d = RX_HIGH;
            RX_HIGH: begin
                if (proto_err) begin
                    state_d = RX_SYNC;
                end else if (bit_done) begin
                    state_d = RX_LOW;
                end
            end
            RX_LOW: begin
                if (s_in) begin
                    state_d = RX_HIGH;
                end else if (gap_seen) begin
                    state_d = RX_IDLE_LOW;
                end
            end
            default:     state_d = RX_SYNC;
        endcase
    end

    // Datapath and pulse outputs: counters, bit shifting, pixel/frame events
    always_comb begin
        high_cnt_d    = high_cnt_q;
        low_cnt_d     = low_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        pix_cnt_d     = pix_cnt_q;
        shift_d       = shift_q;
        overflow_d    = overflow_q;
        pixel_data_d  = pixel_data_q;
        pixel_index_d = pixel_index_q;
        pixel_valid_d = 1'b0;
        frame_done_d  = 1'b0;
        frame_error_d = 1'b0;

        case (state_q)
            RX_SYNC: begin
                // Any high restarts the gap measurement; arming clears it
                if (s_in || sync_armed) begin
                    low_cnt_d = '0;
                end else begin
                    low_cnt_d = low_inc;
                end
            end
            RX_IDLE_LOW: begin
                if (s_in) begin
                    high_cnt_d = HC_ONE;
                end
            end
            RX_HIGH: begin
                if (s_in) begin
                    high_cnt_d = high_inc;
                end
                if (proto_err) begin
                    // Abandon the frame; the partial pixel is lost
                    frame_error_d = 1'b1;
                    bit_cnt_d     = '0;
                    pix_cnt_d     = '0;
                    overflow_d    = 1'b0;
                    low_cnt_d     = '0;
                end else if (bit_done) begin
                    shift_d   = {shift_q[21:0], bit_val};
                    low_cnt_d = LC_ONE;
                    if (pix_done) begin
                        bit_cnt_d = '0;
                        if (pix_room) begin
                            pixel_data_d  = {shift_q, bit_val};
                            pixel_index_d = pix_cnt_q[IDX_W-1:0];
                            pixel_valid_d = 1'b1;
                            pix_cnt_d     = pix_cnt_q + PC_ONE;
                        end else begin
                            overflow_d    = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            RX_LOW: begin
                if (s_in) begin
                    high_cnt_d = HC_ONE;
                end else if (gap_seen) begin
                    // Latch gap: close the frame, flag partial or oversized frames
                    frame_done_d  = 1'b1;
                    frame_error_d = (bit_cnt_q != 5'd0) || overflow_q;
                    bit_cnt_d     = '0;
                    pix_cnt_d     = '0;
                    overflow_d    = 1'b0;
                    low_cnt_d     = '0;
                end else begin
                    low_cnt_d = low_inc;
                end
            end
            default: begin
                low_cnt_d = '0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            high_cnt_q    <= '0;
            low_cnt_q     <= '0;
            bit_cnt_q     <= '0;
            pix_cnt_q     <= '0;
            shift_q       <= '0;
            overflow_q    <= 1'b0;
            pixel_data_q  <= '0;
            pixel_index_q <= '0;
            pixel_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            high_cnt_q    <= high_cnt_d;
            low_cnt_q     <= low_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            pix_cnt_q     <= pix_cnt_d;
            shift_q       <= shift_d;
            overflow_q    <= overflow_d;
            pixel_data_q  <= pixel_data_d;
            pixel_index_q <= pixel_index_d;
            pixel_valid_q <= pixel_valid_d;
            frame_done_q  <= frame_done_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign rx.pixel_data  = pixel_data_q;
    assign rx.pixel_index = pixel_index_q;
    assign rx.pixel_valid = pixel_valid_q;
    assign rx.frame_done  = frame_done_q;
    assign rx.frame_error = frame_error_q;
endmodule

// File: tb/tb_ws2812b_rx.sv
// Scoreboard bench for ws2812b_rx: stimulus pushes expected events, a
// monitor pops and compares them whenever the receiver pulses an output.
module tb_ws2812b_rx;
    import ws2812b_pkg::*;

    localparam int IW = 6;
    localparam int EV_PIX   = 0;
    localparam int EV_FRAME = 1;
    localparam int EV_ERR   = 2;

    typedef struct {
        int          kind;
        logic [23:0] data;
        int          idx;
        bit          err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic serial_in = 1'b0;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    ws2812b_rx_if #(.IDX_W(IW)) rx_if ();

    ws2812b_rx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .serial_in (serial_in),
        .rx        (rx_if)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic lvl, input int n);
        serial_in = lvl;
        tick(n);
    endtask

    task automatic send_bit(input logic b);
        if (b) begin
            drive(1'b1, T1H_CYC);
            drive(1'b0, T1L_CYC);
        end else begin
            drive(1'b1, T0H_CYC);
            drive(1'b0, T0L_CYC);
        end
    endtask

    task automatic send_word(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic gap();
        drive(1'b0, T_RESET_DEF + 20);
    endtask

    task automatic push_pix(input logic [23:0] d, input int idx);
        exp_t e;
        e.kind = EV_PIX; e.data = d; e.idx = idx; e.err = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic push_frame(input bit err);
        exp_t e;
        e.kind = EV_FRAME; e.data = '0; e.idx = 0; e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.kind = EV_ERR; e.data = '0; e.idx = 0; e.err = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end else begin
            $display("check %s = %0h", name, act);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_pixel_data"},  32'(rx_if.pixel_data), 32'h0);
        check_val({tag, "_pixel_index"}, 32'(rx_if.pixel_index), 32'h0);
        check_val({tag, "_pixel_valid"}, 32'(rx_if.pixel_valid), 32'h0);
        check_val({tag, "_frame_done"},  32'(rx_if.frame_done), 32'h0);
        check_val({tag, "_frame_error"}, 32'(rx_if.frame_error), 32'h0);
    endtask

    function automatic logic [23:0] mem_pixel(input int i);
        logic [7:0] g, r, b;
        g = 8'(i * 3);
        r = 8'(255 - i);
        b = 8'(i) ^ 8'h5A;
        return grb_pack(g, r, b);
    endfunction

    // Monitor: compare every output pulse against the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (rx_if.pixel_valid && rx_if.frame_done) begin
                checks++;
                errors++;
                $display("FAIL pulse_overlap actual=valid+done required=exclusive");
            end
            if (rx_if.pixel_valid || rx_if.frame_done || rx_if.frame_error) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse actual=v%0b d%0b e%0b data=%06h idx=%0d required=none",
                             rx_if.pixel_valid, rx_if.frame_done, rx_if.frame_error,
                             rx_if.pixel_data, rx_if.pixel_index);
                end else begin
                    e = exp_q.pop_front();
                    if (rx_if.pixel_valid) begin
                        if (e.kind != EV_PIX || e.data != rx_if.pixel_data ||
                            e.idx != int'(rx_if.pixel_index) || rx_if.frame_error) begin
                            errors++;
                            $display("FAIL pixel actual=data %06h idx %0d err %0b required=kind %0d data %06h idx %0d",
                                     rx_if.pixel_data, rx_if.pixel_index, rx_if.frame_error,
                                     e.kind, e.data, e.idx);
                        end else begin
                            $display("pixel idx=%0d data=%06h", rx_if.pixel_index, rx_if.pixel_data);
                        end
                    end else if (rx_if.frame_done) begin
                        if (e.kind != EV_FRAME || e.err != rx_if.frame_error) begin
                            errors++;
                            $display("FAIL frame_done actual=err %0b required=kind %0d err %0b",
                                     rx_if.frame_error, e.kind, e.err);
                        end else begin
                            $display("frame_done err=%0b", rx_if.frame_error);
                        end
                    end else begin
                        if (e.kind != EV_ERR) begin
                            errors++;
                            $display("FAIL frame_error actual=lone error required=kind %0d", e.kind);
                        end else begin
                            $display("frame_error (protocol violation)");
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst_n = 1'b0;
        serial_in = 1'b0;
        tick(3);
        check_outputs_zero("reset");
        rst_n = 1'b1;

        // Arm, then one pixel 24'hFF0000 followed by a gap
        drive(1'b0, T_RESET_DEF + 10);
        push_pix(24'hFF0000, 0);
        send_word(24'hFF0000);
        push_frame(1'b0);
        gap();

        // Threshold: 6-cycle high -> 0, 7-cycle high -> 1, alternating -> 555555
        push_pix(24'h555555, 0);
        for (int i = 23; i >= 0; i--) begin
            if (i % 2 == 1) begin
                drive(1'b1, 6); drive(1'b0, 9);
            end else begin
                drive(1'b1, 7); drive(1'b0, 8);
            end
        end
        push_frame(1'b0);
        gap();

        // Loopback of a 64-pixel frame from colour tables
        for (int i = 0; i < 64; i++) begin
            push_pix(mem_pixel(i), i);
            send_word(mem_pixel(i));
        end
        push_frame(1'b0);
        gap();

        // 12 bits then a gap: frame_done with frame_error
        for (int i = 0; i < 12; i++) send_bit(i[0]);
        push_frame(1'b1);
        gap();

        // Over-long high after a pixel: error, SYNC, no frame_done on the gap
        push_pix(24'h123456, 0);
        send_word(24'h123456);
        push_err();
        drive(1'b1, 20);
        gap();
        push_pix(24'h0000FF, 0);
        send_word(24'h0000FF);
        push_frame(1'b0);
        gap();

        // Too-short high while armed
        push_err();
        drive(1'b1, 1);
        gap();
        push_pix(24'hA5C3F0, 0);
        send_word(24'hA5C3F0);
        push_pix(24'h0F0F0F, 1);
        send_word(24'h0F0F0F);
        push_frame(1'b0);
        gap();

        // 65 pixels: only 64 reported, error at the gap
        for (int i = 0; i < 65; i++) begin
            if (i < 64) push_pix(mem_pixel(63 - i), i);
            send_word(mem_pixel(63 - i));
        end
        push_frame(1'b1);
        gap();

        // Reset mid-pixel, then traffic before re-arming is ignored
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        rst_n = 1'b0;
        tick(3);
        check_outputs_zero("midreset");
        rst_n = 1'b1;
        drive(1'b0, 100);
        send_word(24'hDEAD01);
        gap();
        push_pix(24'hC0FFEE, 0);
        send_word(24'hC0FFEE);
        push_frame(1'b0);
        gap();

        tick(20);
        check_val("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
